esfa_cell_bank: RTL and testbench
=================================

// Module: esfa_cell_bank
// PURPOSE
//  Parametrised bank of N ESFA memory cells sharing one operation bus: next generation of the single
//  8-bit cell. Adds reset, a valid/ready op/response handshake, saturating arithmetic with error flag,
//  and a priority-reduced bank response (lowest hitting handle wins). Sits between the ESFA controller
//  and the cell storage; handle of cell i is the constant i.
// PARAMETERS
//  N_CELLS   8                  number of cells (>=2)
//  DATA_W    8                  width of index/value/meta/code/rank/low/high fields
//  HANDLE_W  $clog2(N_CELLS)    width of rsp_handle
// PORTS
//  clk            in   1         clock, all state on posedge
//  rst            in   1         synchronous, active-high reset
//  op_valid       in   1         op request valid
//  op_ready       out  1         bank can accept op (high only in IDLE)
//  op_code        in   3         0 UPDATE,1 LOOKUP,2 ENCODE,3 CONGRUE_UP,4 CONGRUE_DOWN,5 MARK_AVAIL,6 ENRANK,7 ENRANGE
//  op_index       in   DATA_W    inserted index / target handle for CONGRUE_*
//  op_value       in   DATA_W    inserted value / base rank for CONGRUE_UP
//  op_meta        in   DATA_W    metadata operand
//  op_meta_valid  in   1         metadata present; for ENRANGE selects high(1)/low(0)
//  rsp_valid      out  1         response valid, held until rsp_ready
//  rsp_ready      in   1         response consumed
//  rsp_hit        out  1         OR of per-cell hits
//  rsp_hit_mask   out  N_CELLS   per-cell hit bits, bit i = cell i
//  rsp_handle     out  HANDLE_W  lowest hitting cell (0 if none)
//  rsp_value      out  DATA_W    result value of rsp_handle cell (0 if none)
//  rsp_context    out  DATA_W    context of rsp_handle cell (0 if none)
//  rsp_err        out  1         some cell suppressed a saturating update
// BEHAVIOUR
//  Reset: all cells arr_def=elt_def=0, all fields 0; FSM IDLE; op_ready=1; all rsp_* =0. Reset beats
//   every other event: reset during EXEC suppresses that op's cell writes; in-flight op dropped, no rsp.
//  FSM IDLE->EXEC on op_valid&&op_ready (op fields captured); EXEC->REDUCE->RESP unconditionally;
//   RESP->IDLE on rsp_ready. Accept edge t => cell state written at t+1, rsp_valid high from t+3.
//   op_valid ignored outside IDLE. rsp_* stable while rsp_valid&&!rsp_ready.
//  Per cell i (mv=op_meta_valid, m=op_meta; "m==i" false for m>=N_CELLS); hit/value/context:
//   UPDATE: hit=mv&&m==i; on hit write arr_def=elt_def=1,code=low=high=i,value=op_value,index=op_index,
//     rank=1; value=context=i.
//   LOOKUP: hit=mv&&elt_def&&index==op_index&&low<=m<=high; value=stored value, context=rank. No write.
//   ENCODE: hit=mv&&arr_def&&m==i; value=context=code.  ENRANK: same hit; value=context=rank.
//   MARK_AVAIL: hit=!elt_def; value=context=i.
//   ENRANGE: hit=elt_def&&m==i; value=context=(mv?high:low).
//   CONGRUE_UP (hit=0): op_index==i&&mv: code=low=high=m+1, rank=op_value+1. Else: arr_def&&mv&&code>m:
//     code+1; elt_def&&mv: low>m -> low+1, high>=m -> high+1.
//   CONGRUE_DOWN (hit=0): op_index==i&&mv: arr_def=0, rank=0. All cells: elt_def&&mv&&m<low: low-1,high-1;
//     else elt_def&&mv&&low<=m<=high: high-1; if resulting low>high or high would go below 0: elt_def=0,
//     arr_def=0. arr_def&&mv&&code>m: code-1.
//  Width rule: all arithmetic DATA_W bits, no wrap. Increment at 2^DATA_W-1 or decrement of code/low at 0:
//   that cell writes nothing for this op, sets its err bit; rsp_err=OR. Other cells update normally.
//  Reduction: priority encoder, lowest index hit selects handle/value/context, registered in REDUCE.
// STRUCTURE
//  esfa_pkg: op-code localparams, FSM state encoding, cell-state field widths/record layout.
//  Sub-module esfa_cell (HANDLE param, DATA_W): registered cell state, combinational next-state and
//   hit/value/context/err; write enable from bank in EXEC. Bank: generate N cells, FSM, priority encoder.
// TESTING
//  1 rst, MARK_AVAIL -> rsp_hit_mask=0xFF, rsp_handle=0, rsp_value=0, rsp_valid 3 cycles after accept.
//  2 UPDATE m=3 mv=1 index=5 value=0x2A -> mask 0x08; LOOKUP index=5 m=3 -> hit, handle 3, value 0x2A, ctx 1.
//  3 after 2: ENCODE m=3 -> value 3; ENRANGE m=3 mv=0 -> 3; CONGRUE_UP index=3 m=3 value=1 -> ENRANK m=3 rank 2, ENRANGE mv=1 high 4.
//  4 after 3: CONGRUE_DOWN index=3 m=4 -> cell 3 cleared; MARK_AVAIL -> mask 0xFF.
//  5 rsp_ready=0 for 5 cycles -> rsp_valid/values stable, op_ready=0, op_valid pulses ignored.
//  6 rst in EXEC of UPDATE m=2 -> no rsp_valid, cell 2 still empty; CONGRUE_UP m=0xFF index=1 on defined cell -> rsp_err=1, state unchanged.

Source files
------------

// File: rtl/esfa_pkg.sv
// Shared definitions for the ESFA cell bank: op codes, FSM encoding and cell flag layout.
package esfa_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_UPDATE       = 3'd0;
    localparam logic [OP_W-1:0] OP_LOOKUP       = 3'd1;
    localparam logic [OP_W-1:0] OP_ENCODE       = 3'd2;
    localparam logic [OP_W-1:0] OP_CONGRUE_UP   = 3'd3;
    localparam logic [OP_W-1:0] OP_CONGRUE_DOWN = 3'd4;
    localparam logic [OP_W-1:0] OP_MARK_AVAIL   = 3'd5;
    localparam logic [OP_W-1:0] OP_ENRANK       = 3'd6;
    localparam logic [OP_W-1:0] OP_ENRANGE      = 3'd7;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC   = 2'd1;
    localparam logic [ST_W-1:0] ST_REDUCE = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP   = 2'd3;

    // Definition flags of one cell; the data fields (code/low/high/value/index/rank) are DATA_W each.
    typedef struct packed {
        logic arr_def;
        logic elt_def;
    } cell_flags_t;

endpackage

// File: rtl/esfa_cell_bank_cell.sv
// One ESFA memory cell: registered state, combinational next state plus hit/value/context/err.
module esfa_cell
    import esfa_pkg::*;
#(
    parameter int HANDLE = 0,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] op_index,
    input  logic [DATA_W-1:0] op_value,
    input  logic [DATA_W-1:0] op_meta,
    input  logic              op_meta_valid,
    output logic              hit,
    output logic [DATA_W-1:0] res_value,
    output logic [DATA_W-1:0] res_context,
    output logic              err
);

    localparam logic [DATA_W-1:0] ID  = DATA_W'(HANDLE);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    localparam logic [DATA_W-1:0] MAX = '1;

    cell_flags_t       flags_q, flags_d, flags_nx;
    logic [DATA_W-1:0] code_q, code_d, code_nx;
    logic [DATA_W-1:0] low_q, low_d, low_nx;
    logic [DATA_W-1:0] high_q, high_d, high_nx;
    logic [DATA_W-1:0] value_q, value_d, value_nx;
    logic [DATA_W-1:0] index_q, index_d, index_nx;
    logic [DATA_W-1:0] rank_q, rank_d, rank_nx;
    logic              mv, m_is_me, idx_is_me, under;

    assign mv        = op_meta_valid;
    assign m_is_me   = (op_meta == ID);
    assign idx_is_me = (op_index == ID);

    always_comb begin
        flags_nx    = flags_q;
        code_nx     = code_q;
        low_nx      = low_q;
        high_nx     = high_q;
        value_nx    = value_q;
        index_nx    = index_q;
        rank_nx     = rank_q;
        hit         = 1'b0;
        res_value   = '0;
        res_context = '0;
        err         = 1'b0;
        under       = 1'b0;
        case (op_code)
            OP_UPDATE: begin
                hit         = mv && m_is_me;
                res_value   = ID;
                res_context = ID;
                if (hit) begin
                    flags_nx = '{arr_def: 1'b1, elt_def: 1'b1};
                    code_nx  = ID;
                    low_nx   = ID;
                    high_nx  = ID;
                    value_nx = op_value;
                    index_nx = op_index;
                    rank_nx  = ONE;
                end
            end
            OP_LOOKUP: begin
                hit = mv && flags_q.elt_def && (index_q == op_index)
                      && (low_q <= op_meta) && (op_meta <= high_q);
                res_value   = value_q;
                res_context = rank_q;
            end
            OP_ENCODE: begin
                hit         = mv && flags_q.arr_def && m_is_me;
                res_value   = code_q;
                res_context = code_q;
            end
            OP_ENRANK: begin
                hit         = mv && flags_q.arr_def && m_is_me;
                res_value   = rank_q;
                res_context = rank_q;
            end
            OP_MARK_AVAIL: begin
                hit         = !flags_q.elt_def;
                res_value   = ID;
                res_context = ID;
            end
            OP_ENRANGE: begin
                hit         = flags_q.elt_def && m_is_me;
                res_value   = mv ? high_q : low_q;
                res_context = mv ? high_q : low_q;
            end
            OP_CONGRUE_UP: begin
                if (idx_is_me && mv) begin
                    if (op_meta == MAX || op_value == MAX) err = 1'b1;
                    code_nx = op_meta + ONE;
                    low_nx  = op_meta + ONE;
                    high_nx = op_meta + ONE;
                    rank_nx = op_value + ONE;
                end else begin
                    if (flags_q.arr_def && mv && code_q > op_meta) begin
                        if (code_q == MAX) err = 1'b1;
                        code_nx = code_q + ONE;
                    end
                    if (flags_q.elt_def && mv) begin
                        if (low_q > op_meta) begin
                            if (low_q == MAX) err = 1'b1;
                            low_nx = low_q + ONE;
                        end
                        if (high_q >= op_meta) begin
                            if (high_q == MAX) err = 1'b1;
                            high_nx = high_q + ONE;
                        end
                    end
                end
            end
            OP_CONGRUE_DOWN: begin
                if (idx_is_me && mv) begin
                    flags_nx.arr_def = 1'b0;
                    rank_nx          = '0;
                end
                if (flags_q.elt_def && mv) begin
                    if (op_meta < low_q) begin
                        if (low_q == '0) err = 1'b1;
                        low_nx = low_q - ONE;
                        if (high_q == '0) under = 1'b1;
                        else              high_nx = high_q - ONE;
                    end else if (op_meta <= high_q) begin
                        if (high_q == '0) under = 1'b1;
                        else              high_nx = high_q - ONE;
                    end
                    // An emptied range invalidates the whole cell.
                    if (under || low_nx > high_nx) begin
                        flags_nx.elt_def = 1'b0;
                        flags_nx.arr_def = 1'b0;
                    end
                end
                if (flags_q.arr_def && mv && code_q > op_meta) begin
                    if (code_q == '0) err = 1'b1;
                    code_nx = code_q - ONE;
                end
            end
            default: ;
        endcase
    end

    // A saturating cell keeps its whole state for this op.
    always_comb begin
        flags_d = flags_q;
        code_d  = code_q;
        low_d   = low_q;
        high_d  = high_q;
        value_d = value_q;
        index_d = index_q;
        rank_d  = rank_q;
        if (we && !err) begin
            flags_d = flags_nx;
            code_d  = code_nx;
            low_d   = low_nx;
            high_d  = high_nx;
            value_d = value_nx;
            index_d = index_nx;
            rank_d  = rank_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            code_q  <= '0;
            low_q   <= '0;
            high_q  <= '0;
            value_q <= '0;
            index_q <= '0;
            rank_q  <= '0;
        end else begin
            flags_q <= flags_d;
            code_q  <= code_d;
            low_q   <= low_d;
            high_q  <= high_d;
            value_q <= value_d;
            index_q <= index_d;
            rank_q  <= rank_d;
        end
    end

endmodule

// File: rtl/esfa_cell_bank.sv
// Bank of N ESFA cells on one op bus: op/response handshake FSM and lowest-handle response reduction.
module esfa_cell_bank
    import esfa_pkg::*;
#(
    parameter int N_CELLS  = 8,
    parameter int DATA_W   = 8,
    parameter int HANDLE_W = $clog2(N_CELLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [DATA_W-1:0]   op_index,
    input  logic [DATA_W-1:0]   op_value,
    input  logic [DATA_W-1:0]   op_meta,
    input  logic                op_meta_valid,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [N_CELLS-1:0]  rsp_hit_mask,
    output logic [HANDLE_W-1:0] rsp_handle,
    output logic [DATA_W-1:0]   rsp_value,
    output logic [DATA_W-1:0]   rsp_context,
    output logic                rsp_err
);

    logic [ST_W-1:0]     state_q, state_d;
    logic [OP_W-1:0]     op_code_q, op_code_d;
    logic [DATA_W-1:0]   op_index_q, op_index_d;
    logic [DATA_W-1:0]   op_value_q, op_value_d;
    logic [DATA_W-1:0]   op_meta_q, op_meta_d;
    logic                op_mv_q, op_mv_d;

    logic [N_CELLS-1:0]  cell_hit, cell_err;
    logic [DATA_W-1:0]   cell_val [N_CELLS];
    logic [DATA_W-1:0]   cell_ctx [N_CELLS];
    logic                cell_we;

    logic [N_CELLS-1:0]  cap_hit_q, cap_hit_d, cap_err_q, cap_err_d;
    logic [DATA_W-1:0]   cap_val_q [N_CELLS];
    logic [DATA_W-1:0]   cap_val_d [N_CELLS];
    logic [DATA_W-1:0]   cap_ctx_q [N_CELLS];
    logic [DATA_W-1:0]   cap_ctx_d [N_CELLS];

    logic                rsp_valid_q, rsp_valid_d;
    logic [N_CELLS-1:0]  rsp_mask_q, rsp_mask_d;
    logic [HANDLE_W-1:0] rsp_handle_q, rsp_handle_d;
    logic [DATA_W-1:0]   rsp_value_q, rsp_value_d;
    logic [DATA_W-1:0]   rsp_ctx_q, rsp_ctx_d;
    logic                rsp_err_q, rsp_err_d;

    logic [HANDLE_W-1:0] sel_handle;
    logic [DATA_W-1:0]   sel_value, sel_ctx;

    assign cell_we = (state_q == ST_EXEC);

    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
            esfa_cell #(
                .HANDLE (gi),
                .DATA_W (DATA_W)
            ) u_cell (
                .clk           (clk),
                .rst           (rst),
                .we            (cell_we),
                .op_code       (op_code_q),
                .op_index      (op_index_q),
                .op_value      (op_value_q),
                .op_meta       (op_meta_q),
                .op_meta_valid (op_mv_q),
                .hit           (cell_hit[gi]),
                .res_value     (cell_val[gi]),
                .res_context   (cell_ctx[gi]),
                .err           (cell_err[gi])
            );
        end
    endgenerate

    // Scanning downward leaves the lowest hitting handle selected.
    always_comb begin
        sel_handle = '0;
        sel_value  = '0;
        sel_ctx    = '0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (cap_hit_q[i]) begin
                sel_handle = HANDLE_W'(i);
                sel_value  = cap_val_q[i];
                sel_ctx    = cap_ctx_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        op_code_d    = op_code_q;
        op_index_d   = op_index_q;
        op_value_d   = op_value_q;
        op_meta_d    = op_meta_q;
        op_mv_d      = op_mv_q;
        cap_hit_d    = cap_hit_q;
        cap_err_d    = cap_err_q;
        cap_val_d    = cap_val_q;
        cap_ctx_d    = cap_ctx_q;
        rsp_mask_d   = rsp_mask_q;
        rsp_handle_d = rsp_handle_q;
        rsp_value_d  = rsp_value_q;
        rsp_ctx_d    = rsp_ctx_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d    = ST_EXEC;
                    op_code_d  = op_code;
                    op_index_d = op_index;
                    op_value_d = op_value;
                    op_meta_d  = op_meta;
                    op_mv_d    = op_meta_valid;
                end
            end
            ST_EXEC: begin
                // Cell results reflect the state before this op's write.
                state_d   = ST_REDUCE;
                cap_hit_d = cell_hit;
                cap_err_d = cell_err;
                cap_val_d = cell_val;
                cap_ctx_d = cell_ctx;
            end
            ST_REDUCE: begin
                state_d      = ST_RESP;
                rsp_mask_d   = cap_hit_q;
                rsp_handle_d = sel_handle;
                rsp_value_d  = sel_value;
                rsp_ctx_d    = sel_ctx;
                rsp_err_d    = |cap_err_q;
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_q == ST_RESP) && !(rsp_valid_q && rsp_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_code_q    <= '0;
            op_index_q   <= '0;
            op_value_q   <= '0;
            op_meta_q    <= '0;
            op_mv_q      <= 1'b0;
            cap_hit_q    <= '0;
            cap_err_q    <= '0;
            cap_val_q    <= '{default: '0};
            cap_ctx_q    <= '{default: '0};
            rsp_valid_q  <= 1'b0;
            rsp_mask_q   <= '0;
            rsp_handle_q <= '0;
            rsp_value_q  <= '0;
            rsp_ctx_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_code_q    <= op_code_d;
            op_index_q   <= op_index_d;
            op_value_q   <= op_value_d;
            op_meta_q    <= op_meta_d;
            op_mv_q      <= op_mv_d;
            cap_hit_q    <= cap_hit_d;
            cap_err_q    <= cap_err_d;
            cap_val_q    <= cap_val_d;
            cap_ctx_q    <= cap_ctx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_mask_q   <= rsp_mask_d;
            rsp_handle_q <= rsp_handle_d;
            rsp_value_q  <= rsp_value_d;
            rsp_ctx_q    <= rsp_ctx_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign op_ready     = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = |rsp_mask_q;
    assign rsp_hit_mask = rsp_mask_q;
    assign rsp_handle   = rsp_handle_q;
    assign rsp_value    = rsp_value_q;
    assign rsp_context  = rsp_ctx_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_esfa_cell_bank.sv
// Directed scoreboard bench for esfa_cell_bank: expected responses queued at issue, checked by a monitor.
module tb_esfa_cell_bank;
    import esfa_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] op_code = '0;
    logic [7:0] op_index = '0, op_value = '0, op_meta = '0;
    logic       op_meta_valid = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_hit;
    logic [7:0] rsp_hit_mask;
    logic [2:0] rsp_handle;
    logic [7:0] rsp_value, rsp_context;
    logic       rsp_err;

    typedef struct {
        logic [7:0] mask;
        logic [2:0] handle;
        logic [7:0] value;
        logic [7:0] ctx;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    esfa_cell_bank dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_code       (op_code),
        .op_index      (op_index),
        .op_value      (op_value),
        .op_meta       (op_meta),
        .op_meta_valid (op_meta_valid),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_hit_mask  (rsp_hit_mask),
        .rsp_handle    (rsp_handle),
        .rsp_value     (rsp_value),
        .rsp_context   (rsp_context),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: a response is consumed on the edge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_rsp: got mask 0x%0h, expected no response", rsp_hit_mask);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_mask",   32'(rsp_hit_mask), 32'(e.mask));
                check("rsp_hit",    32'(rsp_hit),      32'(e.mask != 8'h00));
                check("rsp_handle", 32'(rsp_handle),   32'(e.handle));
                check("rsp_value",  32'(rsp_value),    32'(e.value));
                check("rsp_ctx",    32'(rsp_context),  32'(e.ctx));
                check("rsp_err",    32'(rsp_err),      32'(e.err));
                $display("rsp mask=%02h handle=%0d value=%02h ctx=%02h err=%0b",
                         rsp_hit_mask, rsp_handle, rsp_value, rsp_context, rsp_err);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (!op_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("op_ready_pre", 32'(op_ready), 32'd1);
    endtask

    task automatic send(input logic [2:0] code, input logic [7:0] idx, input logic [7:0] val,
                        input logic [7:0] meta, input logic mv, input logic [7:0] e_mask,
                        input logic [2:0] e_hdl, input logic [7:0] e_val, input logic [7:0] e_ctx,
                        input logic e_err, input int hold);
        exp_t e;
        e = '{mask: e_mask, handle: e_hdl, value: e_val, ctx: e_ctx, err: e_err};
        wait_idle();
        exp_q.push_back(e);
        rsp_ready     = (hold == 0);
        op_code       = code;
        op_index      = idx;
        op_value      = val;
        op_meta       = meta;
        op_meta_valid = mv;
        op_valid      = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        $display("op code=%0d index=%02h value=%02h meta=%02h mv=%0b", code, idx, val, meta, mv);
        repeat (2) @(posedge clk);
        #1 check("lat_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            check("hold_valid", 32'(rsp_valid),    32'd1);
            check("hold_value", 32'(rsp_value),    32'(e_val));
            check("hold_mask",  32'(rsp_hit_mask), 32'(e_mask));
            check("hold_busy",  32'(op_ready),     32'd0);
            op_code  = OP_MARK_AVAIL;
            op_valid = 1'b1;
            @(posedge clk); #1;
            op_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("op_ready_after", 32'(op_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_op_ready",  32'(op_ready),     32'd1);
        check("reset_rsp_valid", 32'(rsp_valid),    32'd0);
        check("reset_rsp_mask",  32'(rsp_hit_mask), 32'd0);
        check("reset_rsp_err",   32'(rsp_err),      32'd0);
        check("reset_rsp_value", 32'(rsp_value),    32'd0);

        // Reset state and single update / lookup.
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_UPDATE,       8'h05, 8'h2A, 8'h03, 1'b1, 8'h08, 3'd3, 8'h03, 8'h03, 1'b0, 0);
        send(OP_LOOKUP,       8'h05, 8'h00, 8'h03, 1'b1, 8'h08, 3'd3, 8'h2A, 8'h01, 1'b0, 0);
        send(OP_LOOKUP,       8'h05, 8'h00, 8'h04, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_ENCODE,       8'h00, 8'h00, 8'h09, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        // Encode / range / congruence up.
        send(OP_ENCODE,       8'h00, 8'h00, 8'h03, 1'b1, 8'h08, 3'd3, 8'h03, 8'h03, 1'b0, 0);
        send(OP_ENRANGE,      8'h00, 8'h00, 8'h03, 1'b0, 8'h08, 3'd3, 8'h03, 8'h03, 1'b0, 0);
        send(OP_CONGRUE_UP,   8'h03, 8'h01, 8'h03, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_ENRANK,       8'h00, 8'h00, 8'h03, 1'b1, 8'h08, 3'd3, 8'h02, 8'h02, 1'b0, 0);
        send(OP_ENRANGE,      8'h00, 8'h00, 8'h03, 1'b1, 8'h08, 3'd3, 8'h04, 8'h04, 1'b0, 0);
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hF7, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        // Congruence down empties cell 3.
        send(OP_CONGRUE_DOWN, 8'h03, 8'h00, 8'h04, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        // Back-pressure: response held, op_valid pulses ignored.
        send(OP_UPDATE,       8'h06, 8'h11, 8'h05, 1'b1, 8'h20, 3'd5, 8'h05, 8'h05, 1'b0, 5);
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hDF, 3'd0, 8'h00, 8'h00, 1'b0, 0);

        // Reset during EXEC drops the op and its write.
        wait_idle();
        op_code = OP_UPDATE; op_index = 8'h01; op_value = 8'h33; op_meta = 8'h02; op_meta_valid = 1'b1;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("op UPDATE meta=02 interrupted by reset");
        for (int k = 0; k < 6; k++) begin
            check("rst_drop_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b0, 0);

        // Saturation leaves the cell untouched and raises err.
        send(OP_UPDATE,       8'h07, 8'h09, 8'h01, 1'b1, 8'h02, 3'd1, 8'h01, 8'h01, 1'b0, 0);
        send(OP_CONGRUE_UP,   8'h01, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b1, 0);
        send(OP_ENCODE,       8'h00, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h01, 8'h01, 1'b0, 0);
        send(OP_ENRANK,       8'h00, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h01, 8'h01, 1'b0, 0);
        send(OP_LOOKUP,       8'h07, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h09, 8'h01, 1'b0, 0);

        // Shifts of non-target cells and priority among several hits.
        send(OP_UPDATE,       8'h02, 8'h04, 8'h00, 1'b1, 8'h01, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_CONGRUE_UP,   8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_ENCODE,       8'h00, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h02, 8'h02, 1'b0, 0);
        send(OP_ENRANGE,      8'h00, 8'h00, 8'h01, 1'b0, 8'h02, 3'd1, 8'h02, 8'h02, 1'b0, 0);
        send(OP_ENRANK,       8'h00, 8'h00, 8'h00, 1'b1, 8'h01, 3'd0, 8'h01, 8'h01, 1'b0, 0);
        send(OP_MARK_AVAIL,   8'h00, 8'h00, 8'h00, 1'b0, 8'hFC, 3'd2, 8'h02, 8'h02, 1'b0, 0);
        send(OP_CONGRUE_DOWN, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_ENCODE,       8'h00, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h01, 8'h01, 1'b0, 0);
        send(OP_ENCODE,       8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0, 0);
        send(OP_ENRANGE,      8'h00, 8'h00, 8'h01, 1'b1, 8'h02, 3'd1, 8'h01, 8'h01, 1'b0, 0);
        send(OP_LOOKUP,       8'h02, 8'h00, 8'h00, 1'b1, 8'h01, 3'd0, 8'h04, 8'h00, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1 check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
